// File: rtl/proc_trace_checker.sv
// proc_trace_checker
// ------------------
// Hardware checker for processor commit traces. Expected (addr, data, dc)
// records are loaded into a FIFO while IDLE, then compared in order against
// the processor's trace stream once go is seen. The result is reported as
// pass/fail, with error counters, first-error capture and an idle timeout.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   exp_val/exp_rdy            expected-record handshake
//   exp_addr/exp_data/exp_dc   expected record (dc = data is don't-care)
//   go                         start checking (IDLE only)
//   clear                      flush FIFO/counters, return to IDLE
//   trace_val/addr/data        processor commit stream
//   busy/pass/fail             decoded state (CHECK/PASS/FAIL)
//   timeout                    FAIL was caused by the idle timeout
//   num_checked/num_errors     saturating 16-bit counters
//   err_addr/err_exp_data/err_act_data   first mismatch capture
//
// Handshake: a record is transferred on a rising clk edge where exp_val and
// exp_rdy are both 1 and clear is 0. exp_rdy depends only on registered state
// (IDLE and FIFO not full), never on exp_val.
module proc_trace_checker #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int DEPTH         = 16,
  parameter int TIMEOUT       = 1000,
  parameter int STOP_ON_ERROR = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          exp_val,
  output logic          exp_rdy,
  input  logic [AW-1:0] exp_addr,
  input  logic [DW-1:0] exp_data,
  input  logic          exp_dc,
  input  logic          go,
  input  logic          clear,
  input  logic          trace_val,
  input  logic [AW-1:0] trace_addr,
  input  logic [DW-1:0] trace_data,
  output logic          busy,
  output logic          pass,
  output logic          fail,
  output logic          timeout,
  output logic [15:0]   num_checked,
  output logic [15:0]   num_errors,
  output logic [AW-1:0] err_addr,
  output logic [DW-1:0] err_exp_data,
  output logic [DW-1:0] err_act_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_PASS, S_FAIL} state_t;

  state_t        state_q, state_d;
  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [15:0]   num_checked_q, num_checked_d;
  logic [15:0]   num_errors_q, num_errors_d;
  logic          timeout_q, timeout_d;
  logic [AW-1:0] err_addr_q, err_addr_d;
  logic [DW-1:0] err_exp_data_q, err_exp_data_d;
  logic [DW-1:0] err_act_data_q, err_act_data_d;

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic          mem_dc   [DEPTH];

  logic [PW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic          head_dc;
  logic          mismatch;

  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign exp_rdy   = (state_q == S_IDLE) && !full;
  assign push      = exp_val && exp_rdy && !clear;

  assign head_addr = mem_addr[rd_ptr_q[PW-1:0]];
  assign head_data = mem_data[rd_ptr_q[PW-1:0]];
  assign head_dc   = mem_dc[rd_ptr_q[PW-1:0]];
  // The dc gate comes first so an unknown trace_data cannot leak into the
  // result when the record marks data as don't-care.
  assign mismatch  = (head_addr != trace_addr) ||
                     (!head_dc && (head_data != trace_data));

  assign busy         = (state_q == S_CHECK);
  assign pass         = (state_q == S_PASS);
  assign fail         = (state_q == S_FAIL);
  assign timeout      = timeout_q;
  assign num_checked  = num_checked_q;
  assign num_errors   = num_errors_q;
  assign err_addr     = err_addr_q;
  assign err_exp_data = err_exp_data_q;
  assign err_act_data = err_act_data_q;

  // Record storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q[PW-1:0]] <= exp_addr;
      mem_data[wr_ptr_q[PW-1:0]] <= exp_data;
      mem_dc[wr_ptr_q[PW-1:0]]   <= exp_dc;
    end
  end

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    idle_d         = idle_q;
    num_checked_d  = num_checked_q;
    num_errors_d   = num_errors_q;
    timeout_d      = timeout_q;
    err_addr_d     = err_addr_q;
    err_exp_data_d = err_exp_data_q;
    err_act_data_d = err_act_data_q;

    if (clear) begin
      state_d        = S_IDLE;
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      idle_d         = '0;
      num_checked_d  = '0;
      num_errors_d   = '0;
      timeout_d      = 1'b0;
      err_addr_d     = '0;
      err_exp_data_d = '0;
      err_act_data_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (push) wr_ptr_d = wr_ptr_q + 1'b1;
          if (go) begin
            state_d = S_CHECK;
            idle_d  = '0;
          end
        end
        S_CHECK: begin
          if (empty) begin
            // Only reachable when go saw an empty FIFO.
            state_d = (num_errors_q == '0) ? S_PASS : S_FAIL;
          end else if (trace_val) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            idle_d   = '0;
            if (num_checked_q != 16'hFFFF) num_checked_d = num_checked_q + 1'b1;
            if (mismatch) begin
              if (num_errors_q != 16'hFFFF) num_errors_d = num_errors_q + 1'b1;
              if (num_errors_q == '0) begin
                err_addr_d     = trace_addr;
                err_exp_data_d = head_data;
                err_act_data_d = trace_data;
              end
            end
            if (mismatch && (STOP_ON_ERROR != 0)) begin
              state_d = S_FAIL;
            end else if (count == (PW+1)'(1)) begin
              state_d = (mismatch || (num_errors_q != '0)) ? S_FAIL : S_PASS;
            end
          end else if (idle_q == IW'(TIMEOUT - 1)) begin
            // This idle cycle would bring the counter to TIMEOUT.
            state_d   = S_FAIL;
            timeout_d = 1'b1;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      idle_q         <= '0;
      num_checked_q  <= '0;
      num_errors_q   <= '0;
      timeout_q      <= 1'b0;
      err_addr_q     <= '0;
      err_exp_data_q <= '0;
      err_act_data_q <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      idle_q         <= idle_d;
      num_checked_q  <= num_checked_d;
      num_errors_q   <= num_errors_d;
      timeout_q      <= timeout_d;
      err_addr_q     <= err_addr_d;
      err_exp_data_q <= err_exp_data_d;
      err_act_data_q <= err_act_data_d;
    end
  end

endmodule

// File: tb/tb_proc_trace_checker.sv
// Directed bench for proc_trace_checker. Two instances share one stimulus
// bus: dut_a stops on the first error, dut_b drains the whole FIFO.
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_proc_trace_checker;

  logic        clk;
  logic        rst;
  logic        exp_val;
  logic [31:0] exp_addr;
  logic [31:0] exp_data;
  logic        exp_dc;
  logic        go;
  logic        clear;
  logic        trace_val;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;

  logic        a_exp_rdy, a_busy, a_pass, a_fail, a_timeout;
  logic [15:0] a_num_checked, a_num_errors;
  logic [31:0] a_err_addr, a_err_exp_data, a_err_act_data;
  logic        b_exp_rdy, b_busy, b_pass, b_fail, b_timeout;
  logic [15:0] b_num_checked, b_num_errors;
  logic [31:0] b_err_addr, b_err_exp_data, b_err_act_data;

  int checks;
  int errors;

  proc_trace_checker #(
    .AW(32), .DW(32), .DEPTH(4), .TIMEOUT(5), .STOP_ON_ERROR(1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .exp_val(exp_val), .exp_rdy(a_exp_rdy), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_dc(exp_dc), .go(go), .clear(clear),
    .trace_val(trace_val), .trace_addr(trace_addr), .trace_data(trace_data),
    .busy(a_busy), .pass(a_pass), .fail(a_fail), .timeout(a_timeout),
    .num_checked(a_num_checked), .num_errors(a_num_errors),
    .err_addr(a_err_addr), .err_exp_data(a_err_exp_data),
    .err_act_data(a_err_act_data)
  );

  proc_trace_checker #(
    .AW(32), .DW(32), .DEPTH(4), .TIMEOUT(5), .STOP_ON_ERROR(0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .exp_val(exp_val), .exp_rdy(b_exp_rdy), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_dc(exp_dc), .go(go), .clear(clear),
    .trace_val(trace_val), .trace_addr(trace_addr), .trace_data(trace_data),
    .busy(b_busy), .pass(b_pass), .fail(b_fail), .timeout(b_timeout),
    .num_checked(b_num_checked), .num_errors(b_num_errors),
    .err_addr(b_err_addr), .err_exp_data(b_err_exp_data),
    .err_act_data(b_err_act_data)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Driver tasks: each drives for exactly one rising edge.
  task automatic idle_cycle();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic dc);
    exp_val = 1'b1; exp_addr = a; exp_data = d; exp_dc = dc;
    @(negedge clk);
    exp_val = 1'b0; exp_dc = 1'b0;
  endtask

  task automatic do_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic trace(input logic [31:0] a, input logic [31:0] d);
    trace_val = 1'b1; trace_addr = a; trace_data = d;
    @(negedge clk);
    trace_val = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; exp_val = 1'b0; exp_addr = '0; exp_data = '0; exp_dc = 1'b0;
    go = 1'b0; clear = 1'b0; trace_val = 1'b0; trace_addr = '0; trace_data = '0;
    @(negedge clk);
    chk("rst_exp_rdy", a_exp_rdy, 1'b1);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_pass_fail", {a_pass, a_fail, a_timeout}, 3'b000);
    chk("rst_counts", {a_num_checked, a_num_errors}, 32'h0);
    rst = 1'b0;

    // 1: three matching records on consecutive cycles
    do_clear();
    push(32'h200, 32'h5, 1'b0);
    push(32'h204, 32'h7, 1'b0);
    push(32'h208, 32'hC, 1'b0);
    do_go();
    chk("t1_busy", a_busy, 1'b1);
    chk("t1_rdy_in_check", a_exp_rdy, 1'b0);
    trace(32'h200, 32'h5);
    trace(32'h204, 32'h7);
    chk("t1_busy_before_last", a_busy, 1'b1);
    trace(32'h208, 32'hC);
    chk("t1_pass", {a_pass, a_fail, b_pass, b_fail}, 4'b1010);
    chk("t1_checked", a_num_checked, 16'd3);
    chk("t1_errors", b_num_errors, 16'd0);

    // 2: second record mismatches on data
    do_clear();
    push(32'h200, 32'h5, 1'b0);
    push(32'h204, 32'h7, 1'b0);
    do_go();
    trace(32'h200, 32'h5);
    chk("t2_busy", a_busy, 1'b1);
    trace(32'h204, 32'h8);
    chk("t2_fail", {a_fail, a_pass, a_timeout}, 3'b100);
    chk("t2_err_addr", a_err_addr, 32'h204);
    chk("t2_err_exp", a_err_exp_data, 32'h7);
    chk("t2_err_act", a_err_act_data, 32'h8);
    chk("t2_checked", a_num_checked, 16'd2);
    chk("t2_b_fail", {b_fail, b_num_errors}, {1'b1, 16'd1});

    // 3: entries 1 and 3 mismatch; a stops, b drains
    do_clear();
    push(32'h300, 32'h1, 1'b0);
    push(32'h304, 32'h2, 1'b0);
    push(32'h308, 32'h3, 1'b0);
    push(32'h30C, 32'h4, 1'b0);
    do_go();
    trace(32'h300, 32'h1);
    trace(32'h304, 32'h9);
    chk("t3_a_fail_early", a_fail, 1'b1);
    chk("t3_b_busy", b_busy, 1'b1);
    trace(32'h308, 32'h3);
    trace(32'h30C, 32'hAA);
    chk("t3_b_fail", {b_fail, b_pass}, 2'b10);
    chk("t3_b_errors", b_num_errors, 16'd2);
    chk("t3_b_checked", b_num_checked, 16'd4);
    chk("t3_b_err_addr", b_err_addr, 32'h304);
    chk("t3_b_err_data", {b_err_exp_data, b_err_act_data}, {32'h2, 32'h9});
    chk("t3_a_frozen", a_num_checked, 16'd2);

    // 4: timeout after five idle CHECK cycles, and trace on cycle five
    do_clear();
    push(32'h400, 32'h1, 1'b0);
    do_go();
    for (int i = 0; i < 4; i++) idle_cycle();
    chk("t4_busy_cycle4", {a_busy, a_timeout}, 2'b10);
    idle_cycle();
    chk("t4_timeout", {a_fail, a_timeout}, 2'b11);
    chk("t4_b_timeout", {b_fail, b_timeout}, 2'b11);
    do_clear();
    chk("t4_clear_timeout", a_timeout, 1'b0);
    push(32'h400, 32'h1, 1'b0);
    do_go();
    for (int i = 0; i < 4; i++) idle_cycle();
    trace(32'h400, 32'h1);
    chk("t4_trace_wins", {a_pass, a_fail, a_timeout}, 3'b100);

    // 5: fill, overflow push ignored, then drain
    do_clear();
    push(32'h600, 32'h0, 1'b0);
    push(32'h604, 32'h1, 1'b0);
    push(32'h608, 32'h2, 1'b0);
    chk("t5_rdy_not_full", a_exp_rdy, 1'b1);
    push(32'h60C, 32'h3, 1'b0);
    chk("t5_rdy_full", a_exp_rdy, 1'b0);
    push(32'h700, 32'h9, 1'b0);
    do_go();
    trace(32'h600, 32'h0);
    trace(32'h604, 32'h1);
    trace(32'h608, 32'h2);
    trace(32'h60C, 32'h3);
    chk("t5_wrap_pass", {a_pass, a_num_checked}, {1'b1, 16'd4});

    // clear mid-CHECK
    do_clear();
    push(32'hA00, 32'h1, 1'b0);
    push(32'hA04, 32'h2, 1'b0);
    do_go();
    trace(32'hA00, 32'h1);
    idle_cycle();
    chk("t5_mid_checked", {a_busy, a_num_checked}, {1'b1, 16'd1});
    do_clear();
    chk("t5_clear_state", {a_busy, a_pass, a_fail}, 3'b000);
    chk("t5_clear_rdy", a_exp_rdy, 1'b1);
    chk("t5_clear_counts", {a_num_checked, a_num_errors}, 32'h0);

    // push in the same cycle as clear is dropped: go then sees empty FIFO
    clear = 1'b1; exp_val = 1'b1; exp_addr = 32'hB00; exp_data = 32'h1;
    @(negedge clk);
    clear = 1'b0; exp_val = 1'b0;
    do_go();
    chk("t5_empty_go_busy", a_busy, 1'b1);
    idle_cycle();
    chk("t5_empty_go_pass", {a_pass, a_num_checked}, {1'b1, 16'd0});

    // push and go together: the record is included
    do_clear();
    exp_val = 1'b1; exp_addr = 32'hC00; exp_data = 32'h3; go = 1'b1;
    @(negedge clk);
    exp_val = 1'b0; go = 1'b0;
    chk("t5_pushgo_busy", a_busy, 1'b1);
    trace(32'hC00, 32'h3);
    chk("t5_pushgo_pass", {a_pass, a_num_checked}, {1'b1, 16'd1});

    // 6: don't-care data
    do_clear();
    push(32'h20C, 32'h0, 1'b1);
    do_go();
    trace(32'h20C, 32'hDEADBEEF);
    chk("t6_dc_pass", {a_pass, a_num_errors}, {1'b1, 16'd0});

    // asynchronous reset mid-CHECK
    do_clear();
    push(32'h900, 32'h1, 1'b0);
    push(32'h904, 32'h2, 1'b0);
    do_go();
    trace(32'h900, 32'h5);
    chk("t6_b_busy_err", {b_busy, b_num_errors}, {1'b1, 16'd1});
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_state", {b_busy, b_pass, b_fail, a_fail}, 4'b0000);
    chk("t6_rst_counts", {b_num_checked, b_num_errors}, 32'h0);
    chk("t6_rst_err", b_err_addr, 32'h0);
    chk("t6_rst_rdy", {a_exp_rdy, b_exp_rdy}, 2'b11);
    @(negedge clk);
    rst = 1'b0;
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_trace_checker.md
Name: proc_trace_checker

Overview:
- Synthesisable checker for processor commit traces. Generalises the per-instruction trace check in the processor test harnesses into hardware.
- Buffers up to DEPTH expected (addr, data) commit records in a FIFO. Compares them in order against the processor's trace_val/trace_addr/trace_data stream.
- Reports pass, fail, or timeout with error counters and first-error capture.
- Sits beside a processor (single-cycle or pipelined) and memory on FPGA or in simulation, so long programs self-check without a testbench.

Parameters:
- AW, 32, trace address width
- DW, 32, trace data width
- DEPTH, 16, expected-record FIFO depth (power of 2, ≥2)
- TIMEOUT, 1000, max cycles in CHECK without a trace_val before failing (≥1)
- STOP_ON_ERROR, 1, 1 = go to FAIL on first mismatch; 0 = count all mismatches and finish the drain

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- exp_val  in  1  expected record valid
- exp_rdy  out  1  checker can accept a record
- exp_addr  in  AW  expected trace address
- exp_data  in  DW  expected trace data
- exp_dc  in  1  1 = data is don't-care (address still compared)
- go  in  1  start checking (honoured in IDLE only)
- clear  in  1  flush FIFO and counters, return to IDLE
- trace_val  in  1  processor committed an instruction this cycle
- trace_addr  in  AW  committed PC
- trace_data  in  DW  committed writeback data
- busy  out  1  state == CHECK
- pass  out  1  state == PASS
- fail  out  1  state == FAIL
- timeout  out  1  FAIL was caused by timeout
- num_checked  out  16  records compared, saturating at 0xFFFF
- num_errors  out  16  mismatches, saturating at 0xFFFF
- err_addr  out  AW  trace_addr of first mismatch
- err_exp_data  out  DW  expected data of first mismatch
- err_act_data  out  DW  actual data of first mismatch

Behaviour:
- rst asynchronously forces: state IDLE, FIFO empty, all counters 0, timeout 0, err_* 0, exp_rdy 1, busy/pass/fail 0.
- States are IDLE, CHECK, PASS, FAIL. All outputs are registered or decoded from state; there are no combinational paths from trace_* to outputs.
- exp_rdy = (state == IDLE) && !full. A push occurs when exp_val && exp_rdy. Exactly DEPTH pushes fill the FIFO; pointers wrap modulo DEPTH.
- IDLE -> CHECK on go. A push and go in the same cycle: the pushed record is included.
- CHECK with FIFO empty and no mismatch pending -> PASS next cycle. An empty FIFO at go gives CHECK for one cycle, then PASS.
- In CHECK, when trace_val is 1:
  - Pop the head record and increment num_checked.
  - A mismatch is: addr differs, or (!dc and data differs). On mismatch, increment num_errors. If it is the first error, capture err_*.
  - If STOP_ON_ERROR and mismatch: go to FAIL next cycle.
  - If the pop empties the FIFO: go to PASS if num_errors (including this compare) is 0, else FAIL.
- trace_val while in CHECK with the FIFO empty cannot occur, because the empty state exits next cycle. trace_val in IDLE, PASS, or FAIL is ignored.
- Idle counter:
  - Resets to 0 on entry to CHECK and on every trace_val.
  - Increments each CHECK cycle without trace_val.
  - Reaching TIMEOUT -> FAIL with timeout = 1.
  - If trace_val arrives in the same cycle the counter would reach TIMEOUT, the trace wins and there is no timeout.
- PASS and FAIL hold until clear or rst.
- clear in any state: next cycle state IDLE, FIFO flushed, counters, err_* and timeout zeroed. clear and go in the same cycle: clear wins. A push in the same cycle as clear is discarded.
- X on trace_data when the record has dc = 1 must not affect the result.

Test Plan:
- Push (0x200,0x5), (0x204,0x7), (0x208,0xC); go; trace those three on consecutive cycles -> pass = 1 the cycle after the third; num_checked = 3, num_errors = 0.
- STOP_ON_ERROR = 1: expect (0x200,0x5), (0x204,0x7); trace (0x200,0x5), then (0x204,0x8) -> fail = 1 next cycle; err_addr = 0x204, err_exp_data = 0x7, err_act_data = 0x8; num_checked = 2.
- STOP_ON_ERROR = 0: four records; entries 1 and 3 mismatch -> drains all four, fail = 1, num_errors = 2, err_* holds entry 1.
- TIMEOUT = 5: one record; go; no trace_val -> fail = 1 and timeout = 1 five cycles after entering CHECK; a trace on cycle 5 instead gives pass.
- Push DEPTH records -> exp_rdy = 0; extra exp_val is ignored. go with no traces, apply clear mid-CHECK -> IDLE, exp_rdy = 1, counters 0.
- Record (0x20C, dc = 1) with trace_data = 0xDEADBEEF -> pass. Assert rst mid-CHECK -> all outputs return to reset values immediately.
